// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word-in / bit-out handshake bundle for bit_serializer
interface bit_serializer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data_i;
   logic              data_valid_i;
   logic              data_ready_o;
   logic              bit_o;
   logic              bit_valid_o;
   logic              word_done_o;
   logic              busy_o;

   // upstream word source and downstream bit sink
   modport master (
      output data_i,
      output data_valid_i,
      input  data_ready_o,
      input  bit_o,
      input  bit_valid_o,
      input  word_done_o,
      input  busy_o
   );

   // the serializer itself
   modport slave (
      input  data_i,
      input  data_valid_i,
      output data_ready_o,
      output bit_o,
      output bit_valid_o,
      output word_done_o,
      output busy_o
   );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial feeder with one-word hold buffer and slot divider
module bit_serializer #(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter int DIV       = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   bit_serializer_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic              ready_q, ready_d;

   logic              accept;
   logic              slot_wrap;
   logic              word_end;
   logic              out_bit;

   assign accept    = bus.data_valid_i && ready_q;
   assign slot_wrap = (div_cnt_q == DIV_LAST);
   assign word_end  = slot_wrap && (bit_cnt_q == BIT_LAST);
   assign out_bit   = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];

   // Outputs are decoded from state so reset clears them without waiting for a clock
   assign bus.busy_o       = (state_q == SHIFT);
   assign bus.bit_valid_o  = (state_q == SHIFT) && (div_cnt_q == '0);
   assign bus.bit_o        = (state_q == SHIFT) && out_bit;
   assign bus.word_done_o  = bus.bit_valid_o && (bit_cnt_q == BIT_LAST);
   assign bus.data_ready_o = ready_q;

   // State register: async reset discards both the active and the held word
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         div_cnt_q   <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         div_cnt_q   <= div_cnt_d;
         ready_q     <= ready_d;
      end
   end

   // Next state: slot pacing, shifting, word hand-off from hold or straight from the input
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d   = bus.data_i;
               bit_cnt_d = '0;
               div_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (slot_wrap) begin
               div_cnt_d = '0;
               if (word_end) begin
                  bit_cnt_d = '0;
                  if (hold_full_q) begin
                     shreg_d     = hold_q;
                     hold_full_d = 1'b0;
                  end else if (accept) begin
                     shreg_d = bus.data_i;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (MSB_FIRST) begin
                     shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                  end else begin
                     shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            // ready is low whenever hold is full, so this never overwrites a held word
            if (accept && !word_end) begin
               hold_d      = bus.data_i;
               hold_full_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = !hold_full_d;
   end
endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer (DIV=1 MSB-first and DIV=3 LSB-first)
module tb_bit_serializer;
   localparam int DW   = 8;
   localparam int MAXC = 4096;
   localparam int QD   = 1024;
   localparam int NONE = -1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   bit_serializer_if #(.DATA_W(DW)) if0 ();
   bit_serializer_if #(.DATA_W(DW)) if1 ();

   bit_serializer #(.DATA_W(DW), .MSB_FIRST(1'b1), .DIV(1)) dut0 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (if0.slave)
   );

   bit_serializer #(.DATA_W(DW), .MSB_FIRST(1'b0), .DIV(3)) dut1 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (if1.slave)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model: per-instance queue of bits still to be emitted
   bit eb [2][QD];
   bit el [2][QD];
   bit ef [2][QD];
   int head [2];
   int tail [2];
   int last_s [2];
   int exp_s [2];
   int unstarted [2];
   bit last_bit [2];
   bit acc_now [2];

   logic obs_bv [2][MAXC];
   logic obs_bt [2][MAXC];
   logic obs_dn [2][MAXC];
   logic obs_bs [2][MAXC];
   logic obs_rd [2][MAXC];

   function automatic int divk(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_clear(input int k);
      head[k]      = 0;
      tail[k]      = 0;
      last_s[k]    = -100;
      exp_s[k]     = NONE;
      unstarted[k] = 0;
      last_bit[k]  = 1'b0;
   endtask

   task automatic model_push(input int k, input logic [DW-1:0] w);
      bit was_empty;
      int ix;
      was_empty = (head[k] == tail[k]);
      for (int i = 0; i < DW; i++) begin
         ix = tail[k] % QD;
         eb[k][ix] = (k == 0) ? w[DW-1-i] : w[i];
         ef[k][ix] = (i == 0);
         el[k][ix] = (i == DW - 1);
         tail[k]++;
      end
      unstarted[k]++;
      if (was_empty) begin
         exp_s[k] = (cyc > last_s[k] + divk(k)) ? cyc : last_s[k] + divk(k);
      end
   endtask

   task automatic model_cycle(input int k, input logic bv, input logic bt, input logic dn,
                              input logic bs, input logic rd);
      bit se;
      bit idle;
      int ix;
      se = (exp_s[k] == cyc);
      chk($sformatf("d%0d_bit_valid@%0d", k, cyc), bv, se);
      if (se) begin
         ix = head[k] % QD;
         head[k]++;
         chk($sformatf("d%0d_bit@%0d", k, cyc), bt, eb[k][ix]);
         chk($sformatf("d%0d_word_done@%0d", k, cyc), dn, el[k][ix]);
         if (ef[k][ix]) unstarted[k]--;
         last_s[k]   = cyc;
         last_bit[k] = eb[k][ix];
         exp_s[k]    = (head[k] != tail[k]) ? cyc + divk(k) : NONE;
      end else begin
         chk($sformatf("d%0d_word_done_low@%0d", k, cyc), dn, 1'b0);
      end
      idle = (exp_s[k] == NONE) && (cyc >= last_s[k] + divk(k));
      chk($sformatf("d%0d_busy@%0d", k, cyc), bs, !idle);
      if (idle) chk($sformatf("d%0d_idle_bit@%0d", k, cyc), bt, 1'b0);
      else if (!se) chk($sformatf("d%0d_bit_hold@%0d", k, cyc), bt, last_bit[k]);
      chk($sformatf("d%0d_ready@%0d", k, cyc), rd, (unstarted[k] == 0));
      if (cyc < MAXC) begin
         obs_bv[k][cyc] = bv;
         obs_bt[k][cyc] = bt;
         obs_dn[k][cyc] = dn;
         obs_bs[k][cyc] = bs;
         obs_rd[k][cyc] = rd;
      end
   endtask

   task automatic set_in(input int k, input logic v, input logic [DW-1:0] d);
      if (k == 0) begin
         if0.data_valid_i = v;
         if0.data_i       = d;
      end else begin
         if1.data_valid_i = v;
         if1.data_i       = d;
      end
   endtask

   task automatic step();
      bit a0, a1;
      logic [DW-1:0] d0, d1;
      a0 = if0.data_valid_i && if0.data_ready_o;
      a1 = if1.data_valid_i && if1.data_ready_o;
      d0 = if0.data_i;
      d1 = if1.data_i;
      @(posedge clk);
      cyc++;
      acc_now[0] = a0;
      acc_now[1] = a1;
      if (a0) model_push(0, d0);
      if (a1) model_push(1, d1);
      #1;
      model_cycle(0, if0.bit_valid_o, if0.bit_o, if0.word_done_o, if0.busy_o, if0.data_ready_o);
      model_cycle(1, if1.bit_valid_o, if1.bit_o, if1.word_done_o, if1.busy_o, if1.data_ready_o);
   endtask

   task automatic reset_outputs_chk(input string s);
      chk({s, "_d0_ready"}, if0.data_ready_o, 1'b0);
      chk({s, "_d0_bit"}, if0.bit_o, 1'b0);
      chk({s, "_d0_bit_valid"}, if0.bit_valid_o, 1'b0);
      chk({s, "_d0_word_done"}, if0.word_done_o, 1'b0);
      chk({s, "_d0_busy"}, if0.busy_o, 1'b0);
      chk({s, "_d1_ready"}, if1.data_ready_o, 1'b0);
      chk({s, "_d1_bit"}, if1.bit_o, 1'b0);
      chk({s, "_d1_bit_valid"}, if1.bit_valid_o, 1'b0);
      chk({s, "_d1_word_done"}, if1.word_done_o, 1'b0);
      chk({s, "_d1_busy"}, if1.busy_o, 1'b0);
   endtask

   initial begin
      int a, nacc, guard, ns, nm, m0, m1, cntb, e0, nstb, ndone;
      int acc_c [3];
      logic [DW-1:0] words [3];
      logic [DW-1:0] pat;
      logic [3:0] sr;
      logic sb [64];

      model_clear(0);
      model_clear(1);
      set_in(0, 1'b0, '0);
      set_in(1, 1'b0, '0);

      // reset values, asynchronous assertion
      #1 rst_n = 1'b0;
      #2 reset_outputs_chk("rst_async");
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      #1 reset_outputs_chk("rst_held");
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("rst_release_d0_ready", if0.data_ready_o, 1'b1);
      chk("rst_release_d1_ready", if1.data_ready_o, 1'b1);

      // single word 8'hB0, MSB first, DIV=1
      pat = 8'hB0;
      set_in(0, 1'b1, pat);
      step();
      a = cyc;
      chk("single_accept", acc_now[0], 1'b1);
      set_in(0, 1'b0, '0);
      repeat (10) step();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("single_bit%0d", i), obs_bt[0][a+i], pat[7-i]);
         chk($sformatf("single_bv%0d", i), obs_bv[0][a+i], 1'b1);
         chk($sformatf("single_done%0d", i), obs_dn[0][a+i], (i == 7));
      end
      chk("single_busy_fall", obs_bs[0][a+8], 1'b0);
      chk("single_bv_after", obs_bv[0][a+8], 1'b0);

      // back-to-back 0B, B0, FF with data_valid held high
      words[0] = 8'h0B;
      words[1] = 8'hB0;
      words[2] = 8'hFF;
      nacc  = 0;
      guard = 0;
      set_in(0, 1'b1, words[0]);
      while (nacc < 3 && guard < 60) begin
         step();
         guard++;
         if (acc_now[0]) begin
            acc_c[nacc] = cyc;
            nacc++;
            if (nacc < 3) set_in(0, 1'b1, words[nacc]);
            else set_in(0, 1'b0, '0);
         end
      end
      set_in(0, 1'b0, '0);
      chk("b2b_accepts", nacc, 3);
      repeat (30) step();
      if (nacc == 3) begin
         a = acc_c[0];
         chk("b2b_acc2", acc_c[1], a + 1);
         chk("b2b_acc3", acc_c[2], a + 9);
         nstb  = 0;
         ndone = 0;
         for (int c = a; c < a + 24; c++) begin
            if (obs_bv[0][c] === 1'b1) nstb++;
            if (obs_dn[0][c] === 1'b1) ndone++;
         end
         chk("b2b_strobes", nstb, 24);
         chk("b2b_dones", ndone, 3);
         chk("b2b_bv_end", obs_bv[0][a+24], 1'b0);
         chk("b2b_done1", obs_dn[0][a+7], 1'b1);
         chk("b2b_done2", obs_dn[0][a+15], 1'b1);
         chk("b2b_done3", obs_dn[0][a+23], 1'b1);
         chk("b2b_rdy_a", obs_rd[0][a], 1'b1);
         chk("b2b_rdy_drop", obs_rd[0][a+1], 1'b0);
         chk("b2b_rdy_drain1", obs_rd[0][a+8], 1'b1);
         chk("b2b_rdy_drop2", obs_rd[0][a+9], 1'b0);
         chk("b2b_rdy_drain2", obs_rd[0][a+16], 1'b1);
      end

      // DIV=3, LSB first, 8'h0D, then a same-edge handoff at its end-of-word edge
      pat = 8'h0D;
      set_in(1, 1'b1, pat);
      step();
      a = cyc;
      chk("div3_accept", acc_now[1], 1'b1);
      set_in(1, 1'b0, '0);
      repeat (23) step();
      set_in(1, 1'b1, 8'h5A);
      step();
      chk("handoff_accept", acc_now[1], 1'b1);
      set_in(1, 1'b0, '0);
      repeat (30) step();
      for (int i = 0; i < 24; i++) begin
         chk($sformatf("div3_bv%0d", i), obs_bv[1][a+i], (i % 3 == 0));
         chk($sformatf("div3_bit%0d", i), obs_bt[1][a+i], pat[i/3]);
         chk($sformatf("div3_done%0d", i), obs_dn[1][a+i], (i == 21));
         chk($sformatf("div3_busy%0d", i), obs_bs[1][a+i], 1'b1);
      end
      chk("handoff_bv", obs_bv[1][a+24], 1'b1);
      chk("handoff_bit", obs_bt[1][a+24], 1'b0);
      chk("handoff_ready", obs_rd[1][a+24], 1'b1);
      chk("handoff_bit2", obs_bt[1][a+27], 1'b1);

      // reset mid-word with a second word in hold
      set_in(0, 1'b1, 8'hC3);
      step();
      a = cyc;
      set_in(0, 1'b1, 8'h3C);
      step();
      set_in(0, 1'b0, '0);
      chk("rmid_hold_ready", obs_rd[0][a+1], 1'b0);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1 reset_outputs_chk("rst_mid");
      model_clear(0);
      model_clear(1);
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      #1 reset_outputs_chk("rst_mid_held");
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("rmid_release_ready", if0.data_ready_o, 1'b1);
      repeat (12) step();

      // detector integration: B0 then 0B, look for non-overlapping 1011
      e0 = cyc + 1;
      nacc  = 0;
      guard = 0;
      set_in(0, 1'b1, 8'hB0);
      while (nacc < 2 && guard < 40) begin
         step();
         guard++;
         if (acc_now[0]) begin
            nacc++;
            if (nacc == 1) set_in(0, 1'b1, 8'h0B);
            else set_in(0, 1'b0, '0);
         end
      end
      set_in(0, 1'b0, '0);
      repeat (20) step();
      ns = 0;
      for (int c = e0; c <= cyc; c++) begin
         if (obs_bv[0][c] === 1'b1 && ns < 64) begin
            sb[ns] = obs_bt[0][c];
            ns++;
         end
      end
      nm   = 0;
      m0   = -1;
      m1   = -1;
      cntb = 0;
      sr   = '0;
      for (int i = 0; i < ns; i++) begin
         sr = {sr[2:0], sb[i]};
         cntb++;
         if (cntb >= 4 && sr == 4'b1011) begin
            if (nm == 0) m0 = i;
            else if (nm == 1) m1 = i;
            nm++;
            cntb = 0;
         end
      end
      chk("det_strobes", ns, 16);
      chk("det_matches", nm, 2);
      chk("det_match0", m0, 3);
      chk("det_match1", m1, 15);

      // randomized traffic on both instances against the model
      for (int n = 0; n < 800; n++) begin
         set_in(0, ($urandom_range(0, 2) != 0), DW'($urandom));
         set_in(1, ($urandom_range(0, 3) == 0), DW'($urandom));
         step();
      end
      set_in(0, 1'b0, '0);
      set_in(1, 1'b0, '0);
      repeat (60) step();
      chk("rand_d0_drained", tail[0] - head[0], 0);
      chk("rand_d1_drained", tail[1] - head[1], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
